// File: rtl/binary_pixel_packer.sv
// Packs the 1-bit binarized pixel stream into DATA_W-bit words, MSB first.
// Optional foreground statistics are built when BIN_PACK_STATS_EN is defined.
module binary_pixel_packer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vsync,
    input  logic              in_href,
    input  logic              in_clken,
    input  logic              in_bit,
    input  logic              wr_full,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_start,
    output logic              overflow,
    output logic [CNT_W-1:0]  fg_count,
    output logic              fg_valid
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic              vsync_d;
    logic              href_d;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sreg;

    logic              accept;
    logic              vsync_rise;
    logic              href_fall;
    logic              complete;
    logic              flush;
    logic              pend;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] word;
    logic [CW-1:0]     cnt_nxt;
    logic [DATA_W-1:0] sreg_nxt;

    assign accept     = in_href & in_clken;
    assign vsync_rise = in_vsync & ~vsync_d;
    assign href_fall  = ~in_href & href_d;
    assign complete   = accept & (cnt == LAST);
    // A new frame discards a partial word instead of flushing it
    assign flush      = href_fall & (cnt != '0) & ~vsync_rise;
    assign pend       = complete | flush;

    // Word assembly and next packing state
    always_comb begin
        mask     = {{(DATA_W-1){1'b0}}, 1'b1} << (LAST - cnt);
        word     = sreg;
        cnt_nxt  = cnt;
        sreg_nxt = sreg;
        if (complete) begin
            word = sreg | (mask & {DATA_W{in_bit}});
        end
        if (complete) begin
            cnt_nxt  = '0;
            sreg_nxt = '0;
        end else if (vsync_rise) begin
            cnt_nxt  = accept ? CW'(1) : '0;
            sreg_nxt = {accept & in_bit, {(DATA_W-1){1'b0}}};
        end else if (flush) begin
            cnt_nxt  = '0;
            sreg_nxt = '0;
        end else if (accept) begin
            cnt_nxt  = cnt + CW'(1);
            sreg_nxt = sreg | (mask & {DATA_W{in_bit}});
        end
    end

    // Packing state, edge-detect copies and write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d     <= 1'b0;
            href_d      <= 1'b0;
            cnt         <= '0;
            sreg        <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            frame_start <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            vsync_d     <= in_vsync;
            href_d      <= in_href;
            cnt         <= cnt_nxt;
            sreg        <= sreg_nxt;
            frame_start <= vsync_rise;
            wr_en       <= pend & ~wr_full;
            if (pend && !wr_full) begin
                wr_data <= word;
            end
            if (pend && wr_full) begin
                overflow <= 1'b1;
            end else if (vsync_rise) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef BIN_PACK_STATS_EN
    logic [CNT_W-1:0] fg_int;
    logic [CNT_W-1:0] fg_inc;

    assign fg_inc = (accept && in_bit && (fg_int != {CNT_W{1'b1}}))
                    ? fg_int + CNT_W'(1) : fg_int;

    // Saturating foreground count, published at each frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fg_int   <= '0;
            fg_count <= '0;
            fg_valid <= 1'b0;
        end else begin
            fg_valid <= vsync_rise;
            if (vsync_rise) begin
                fg_count <= fg_inc;
                fg_int   <= '0;
            end else begin
                fg_int   <= fg_inc;
            end
        end
    end
`else
    assign fg_count = {CNT_W{1'b0}};
    assign fg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_binary_pixel_packer.sv
// Scoreboard bench for binary_pixel_packer at DATA_W=8, CNT_W=4.
// Expected words are queued by the stimulus; a monitor pops on each write.
module tb_binary_pixel_packer;

    localparam int DW = 8;
    localparam int CN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vsync = 1'b0;
    logic          in_href = 1'b0;
    logic          in_clken = 1'b0;
    logic          in_bit = 1'b0;
    logic          wr_full = 1'b0;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          frame_start;
    logic          overflow;
    logic [CN-1:0] fg_count;
    logic          fg_valid;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    binary_pixel_packer #(.DATA_W(DW), .CNT_W(CN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vsync(in_vsync), .in_href(in_href),
        .in_clken(in_clken), .in_bit(in_bit),
        .wr_full(wr_full), .wr_en(wr_en), .wr_data(wr_data),
        .frame_start(frame_start), .overflow(overflow),
        .fg_count(fg_count), .fg_valid(fg_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h required=none",
                         wr_data);
            end else begin
                chk("wr_data", 64'(wr_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc(input logic v, input logic h,
                       input logic c, input logic b);
        @(posedge clk);
        #1;
        in_vsync = v;
        in_href  = h;
        in_clken = c;
        in_bit   = b;
    endtask

    task automatic line(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b1, bits[n-1-i]);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #12;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_frame_start", 64'(frame_start), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // 1,0,1,1,0,0,0,1
        exp_q.push_back(8'hB1);
        line(32'hB1, 8);

        // 11 ones: full word then flushed remainder
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hE0);
        line(32'h7FF, 11);

        // 16 alternating pixels, no flush
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAA);
        line(32'hAAAA, 16);
        chk("no_overflow_yet", 64'(overflow), 64'd0);

        // FIFO full during the second word
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1);
            if (i == 8) wr_full = 1'b1;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        wr_full = 1'b0;
        idle(1);
        chk("overflow_set", 64'(overflow), 64'd1);
        chk("wr_data_held", 64'(wr_data), 64'hFF);

        // vsync rise: frame_start pulse, overflow cleared
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fs_not_early", 64'(frame_start), 64'd0);
        @(posedge clk);
        #1;
        chk("frame_start", 64'(frame_start), 64'd1);
        chk("overflow_clr", 64'(overflow), 64'd0);
        in_vsync = 1'b0;
        @(posedge clk);
        #1;
        chk("fs_one_cycle", 64'(frame_start), 64'd0);
        idle(2);

        // 5 pixels, vsync rises mid-line: partial word discarded
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        exp_q.push_back(8'h0F);
        line(32'h0F, 8);

        // Stats frame: restart count, 20 foreground pixels
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF0);
        line(32'hFFFFF, 20);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("stats_frame_start", 64'(frame_start), 64'd1);
`ifdef BIN_PACK_STATS_EN
        chk("fg_valid", 64'(fg_valid), 64'd1);
        chk("fg_count_sat", 64'(fg_count), 64'hF);
`else
        chk("fg_valid_tied", 64'(fg_valid), 64'd0);
        chk("fg_count_tied", 64'(fg_count), 64'd0);
`endif
        idle(2);

        // Set overflow again, then reset mid-line
        exp_q.push_back(8'h55);
        line(32'h55, 8);
        wr_full = 1'b1;
        line(32'h3C, 8);
        wr_full = 1'b0;
        chk("overflow_again", 64'(overflow), 64'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        chk("mid_rst_fs", 64'(frame_start), 64'd0);
        chk("mid_rst_fg_count", 64'(fg_count), 64'd0);
        chk("mid_rst_fg_valid", 64'(fg_valid), 64'd0);
        in_href  = 1'b0;
        in_clken = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        exp_q.push_back(8'hC3);
        line(32'hC3, 8);

        idle(5);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
